// File: rtl/innerproduct_seq_ctrl.sv
// Sequential window inner product: one MAC per cycle over N_TAPS latched pixels,
// theta fetched from an external combinational coefficient table.
module innerproduct_seq_ctrl #(
    parameter int N_TAPS = 81,
    parameter int PIX_W  = 7,
    parameter int ACC_W  = 32,
    parameter int ADDR_W = 7
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [N_TAPS*PIX_W-1:0]   pix_in,
    output logic [ADDR_W-1:0]         coef_addr,
    input  logic [ACC_W-1:0]          coef_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ACC_W-1:0]          hprime,
    output logic                      busy
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_TAPS - 1);

    state_t                    state, state_nxt;
    logic [ADDR_W-1:0]         idx, idx_nxt;
    logic [ACC_W-1:0]          acc, acc_nxt, prod;
    logic [N_TAPS*PIX_W-1:0]   win;
    logic                      load;
    logic [PIX_W-1:0]          taps [N_TAPS];

    for (genvar k = 0; k < N_TAPS; k++) begin : g_tap
        assign taps[k] = win[k*PIX_W +: PIX_W];
    end

    // Pixel is zero-extended; the product is kept at ACC_W so signed theta wraps correctly.
    assign prod = ACC_W'(taps[idx]) * coef_data;
    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            acc   <= '0;
            win   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            acc   <= acc_nxt;
            if (load) win <= pix_in;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        acc_nxt   = acc;
        load      = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        coef_addr = '0;
        hprime    = '0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load      = 1'b1;
                    idx_nxt   = '0;
                    acc_nxt   = '0;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                coef_addr = idx;
                acc_nxt   = acc + prod;
                // idx parks on the last tap so coef_addr stays inside the table
                if (idx == LAST) state_nxt = DONE;
                else             idx_nxt   = idx + ADDR_W'(1);
            end
            DONE: begin
                out_valid = 1'b1;
                hprime    = acc;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_innerproduct_seq_ctrl.sv
// Scoreboard bench for innerproduct_seq_ctrl: expected hprime pushed on accept,
// popped when out_valid is seen.
module tb_innerproduct_seq_ctrl;

    localparam int N = 81;
    localparam int PW = 7;
    localparam int AW = 32;

    logic              clk = 0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [N*PW-1:0]   pix_in;
    logic [6:0]        coef_addr;
    logic [AW-1:0]     coef_data;
    logic              out_valid;
    logic              out_ready;
    logic [AW-1:0]     hprime;
    logic              busy;

    int                pass_cnt = 0;
    int                total    = 0;
    int                mode     = 0;
    logic [AW-1:0]     sb [$];

    innerproduct_seq_ctrl #(.N_TAPS(N), .PIX_W(PW), .ACC_W(AW), .ADDR_W(7)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .pix_in(pix_in), .coef_addr(coef_addr), .coef_data(coef_data),
        .out_valid(out_valid), .out_ready(out_ready), .hprime(hprime), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [AW-1:0] coef_f(input int m, input logic [6:0] a);
        case (m)
            0:       return AW'(a) + 32'd1;
            1:       return 32'd1;
            2:       return 32'h0400_0000;
            default: return AW'(a) * 32'h9E37_79B1 + 32'h0000_1234;
        endcase
    endfunction

    always_comb coef_data = coef_f(mode, coef_addr);

    function automatic logic [AW-1:0] model(input logic [N*PW-1:0] w, input int m);
        logic [AW-1:0] s = '0;
        for (int k = 0; k < N; k++)
            s = s + AW'(w[k*PW +: PW]) * coef_f(m, 7'(k));
        return s;
    endfunction

    function automatic logic [N*PW-1:0] rand_win();
        logic [N*PW-1:0] w;
        for (int k = 0; k < N; k++) w[k*PW +: PW] = PW'($urandom_range(0, 127));
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a window until accepted, push its expected result, then scramble pix_in.
    task automatic accept(input logic [N*PW-1:0] w, input int m);
        bit ok = 0;
        mode     = m;
        pix_in   = w;
        in_valid = 1'b1;
        for (int c = 0; c < 400 && !ok; c++) begin
            ok = in_ready;
            tick();
        end
        in_valid = 1'b0;
        total++;
        if (!ok) $display("FAIL accept_timeout: in_ready never seen");
        else begin
            pass_cnt++;
            sb.push_back(model(w, m));
        end
        pix_in = rand_win();
    endtask

    task automatic get_result(input string name);
        bit seen = 0;
        logic [AW-1:0] exp_v;
        out_ready = 1'b1;
        for (int c = 0; c < 400 && !seen; c++) begin
            if (out_valid) seen = 1;
            else tick();
        end
        total++;
        if (!seen || sb.size() == 0) begin
            $display("FAIL %s_timeout: out_valid=%0b queue=%0d", name, out_valid, sb.size());
        end else begin
            exp_v = sb.pop_front();
            if (hprime !== exp_v)
                $display("FAIL %s: hprime=%h expected=%h", name, hprime, exp_v);
            else pass_cnt++;
        end
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 0; out_ready = 0; pix_in = '0;
        #12;
        total++;
        if ({in_ready, out_valid, busy, hprime, coef_addr} !== {3'b100, 32'd0, 7'd0})
            $display("FAIL reset: rdy=%b ov=%b busy=%b hp=%h ca=%h want 1 0 0 0 0",
                     in_ready, out_valid, busy, hprime, coef_addr);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_zero();
        accept('0, 0);
        get_result("zero_window");
    endtask

    task automatic test_latency();
        logic [N*PW-1:0] w = '0;
        bit bad = 0;
        w[40*PW +: PW] = 7'd1;
        accept(w, 0);
        // now just after accept edge E; sample after E+j for j=0..80
        for (int j = 0; j < N; j++) begin
            if (out_valid !== 1'b0 || coef_addr !== 7'(j) || busy !== 1'b1) bad = 1;
            if (j < N - 1) tick();
        end
        total++;
        if (bad) $display("FAIL latency_run: out_valid/coef_addr sequence wrong during RUN");
        else pass_cnt++;
        tick();
        total++;
        if (out_valid !== 1'b1 || hprime !== 32'd41)
            $display("FAIL latency_done: out_valid=%b hprime=%0d expected 1 41", out_valid, hprime);
        else pass_cnt++;
        get_result("single_tap");
    endtask

    task automatic test_const(input int m, input logic [AW-1:0] want, input string name);
        accept({N{7'd127}}, m);
        for (int c = 0; c < 200 && !out_valid; c++) tick();
        total++;
        if (hprime !== want) $display("FAIL %s: hprime=%h expected=%h", name, hprime, want);
        else pass_cnt++;
        get_result(name);
    endtask

    task automatic test_backpressure();
        logic [AW-1:0] held;
        logic [N*PW-1:0] w2 = rand_win();
        bit bad = 0;
        accept(rand_win(), 3);
        out_ready = 1'b0;
        for (int c = 0; c < 200 && !out_valid; c++) tick();
        held     = hprime;
        pix_in   = w2;
        in_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (out_valid !== 1'b1 || hprime !== held || in_ready !== 1'b0) bad = 1;
        end
        total++;
        if (bad) $display("FAIL backpressure_hold: out_valid=%b hprime=%h held=%h in_ready=%b",
                          out_valid, hprime, held, in_ready);
        else pass_cnt++;
        get_result("backpressure_first");
        // DONE->IDLE edge just passed with in_valid high: must not have been taken
        total++;
        if (busy !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL done_idle_edge: busy=%b in_ready=%b expected 0 1", busy, in_ready);
        else pass_cnt++;
        accept(w2, 3);
        get_result("backpressure_second");
    endtask

    task automatic test_reset_mid_run();
        accept(rand_win(), 3);
        for (int j = 0; j < 29; j++) tick();
        rst = 1'b1;
        #1;
        total++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1 || coef_addr !== 7'd0)
            $display("FAIL async_reset: busy=%b ov=%b rdy=%b ca=%h want 0 0 1 0",
                     busy, out_valid, in_ready, coef_addr);
        else pass_cnt++;
        void'(sb.pop_front());
        @(negedge clk);
        rst = 1'b0;
        tick();
        accept(rand_win(), 3);
        get_result("after_reset");
    endtask

    task automatic test_back_to_back();
        logic [N*PW-1:0] w = rand_win();
        int acc_cyc[2];
        int n_acc = 0, n_res = 0;
        logic [AW-1:0] exp_v;
        mode = 3; pix_in = w; in_valid = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 400 && n_res < 2; c++) begin
            if (in_valid && in_ready) begin
                acc_cyc[n_acc] = c;
                n_acc++;
                sb.push_back(model(w, 3));
            end
            if (out_valid) begin
                n_res++;
                exp_v = sb.pop_front();
                total++;
                if (hprime !== exp_v) $display("FAIL b2b_result: hprime=%h expected=%h", hprime, exp_v);
                else pass_cnt++;
            end
            tick();
            if (n_acc == 2) in_valid = 1'b0;
        end
        out_ready = 1'b0;
        total++;
        if (n_acc != 2 || acc_cyc[1] - acc_cyc[0] != N + 2)
            $display("FAIL b2b_spacing: accepts=%0d spacing=%0d expected %0d",
                     n_acc, acc_cyc[1] - acc_cyc[0], N + 2);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_zero();
        test_latency();
        test_const(1, 32'h0000_282F, "all127_coef1");
        test_const(2, 32'hBC00_0000, "all127_wrap");
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
